// File: rtl/envelope_sequencer_pkg.sv
// Shared definitions for the ADSR envelope sequencer: stage encoding and
// amplitude range helpers.
package envelope_sequencer_pkg;

    localparam int AMPLITUDE_BITS_DEFAULT = 8;
    localparam int RATE_BITS_DEFAULT      = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    function automatic int amplitude_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    localparam int AMPLITUDE_MAX = amplitude_max(AMPLITUDE_BITS_DEFAULT);

endpackage

// File: rtl/envelope_sequencer_rate_prescaler.sv
// Tick prescaler: emits a step on the tick where the count equals rate.
// A rate of 0 steps on every tick. Reusable for LFO/vibrato rate generation.
module rate_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] rate,
    input  logic             clear,
    output logic             step
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign step = tick && (cnt_q == rate);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = step ? '0 : cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/envelope_sequencer.sv
// Per-voice ADSR envelope: steps the amplitude through attack, decay,
// sustain and release at tick-based rates; all outputs registered.
module envelope_sequencer
    import envelope_sequencer_pkg::*;
#(
    parameter int AMPLITUDE_BITS = AMPLITUDE_BITS_DEFAULT,
    parameter int RATE_BITS      = RATE_BITS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      note_on,
    input  logic                      note_off,
    input  logic [RATE_BITS-1:0]      attack_rate,
    input  logic [RATE_BITS-1:0]      decay_rate,
    input  logic [AMPLITUDE_BITS-1:0] sustain_level,
    input  logic [RATE_BITS-1:0]      release_rate,
    output logic [AMPLITUDE_BITS-1:0] amplitude,
    output logic                      active,
    output logic [2:0]                stage
);

    localparam logic [AMPLITUDE_BITS-1:0] AMP_MAX =
        AMPLITUDE_BITS'(amplitude_max(AMPLITUDE_BITS));
    localparam logic [AMPLITUDE_BITS-1:0] AMP_NEAR_MAX =
        AMPLITUDE_BITS'(amplitude_max(AMPLITUDE_BITS) - 1);
    localparam logic [AMPLITUDE_BITS-1:0] AMP_ONE = AMPLITUDE_BITS'(1);

    env_state_e                state_q;
    env_state_e                state_d;
    logic [AMPLITUDE_BITS-1:0] amp_q;
    logic [AMPLITUDE_BITS-1:0] amp_d;
    logic                      active_q;
    logic                      active_d;
    logic [RATE_BITS-1:0]      rate_sel;
    logic                      step;
    logic                      clear;
    logic                      release_ok;

    assign release_ok = note_off &&
        (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN);

    always_comb begin
        rate_sel = '0;
        case (state_q)
            ST_ATTACK:  rate_sel = attack_rate;
            ST_DECAY:   rate_sel = decay_rate;
            ST_RELEASE: rate_sel = release_rate;
            default:    rate_sel = '0;
        endcase
    end

    rate_prescaler #(
        .WIDTH (RATE_BITS)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .rate  (rate_sel),
        .clear (clear),
        .step  (step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            amp_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            amp_q    <= amp_d;
            active_q <= active_d;
        end
    end

    // Note events take priority over any pending stage progression.
    always_comb begin
        state_d = state_q;
        if (note_on) begin
            state_d = ST_ATTACK;
        end else if (release_ok) begin
            state_d = ST_RELEASE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_IDLE;
                ST_ATTACK:  if (step && amp_q >= AMP_NEAR_MAX) state_d = ST_DECAY;
                ST_DECAY:   if (amp_q <= sustain_level) state_d = ST_SUSTAIN;
                ST_SUSTAIN: state_d = ST_SUSTAIN;
                ST_RELEASE: if (amp_q == '0) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        amp_d = amp_q;
        case (state_q)
            ST_IDLE:    amp_d = '0;
            ST_ATTACK:  if (step) amp_d = (amp_q == AMP_MAX) ? AMP_MAX : amp_q + AMP_ONE;
            ST_DECAY: begin
                if (amp_q <= sustain_level) begin
                    amp_d = sustain_level;
                end else if (step) begin
                    amp_d = amp_q - AMP_ONE;
                end
            end
            ST_SUSTAIN: amp_d = sustain_level;
            ST_RELEASE: if (step && amp_q != '0) amp_d = amp_q - AMP_ONE;
            default:    amp_d = '0;
        endcase
        // A note event discards any coincident step; amplitude carries over.
        if (note_on || release_ok) begin
            amp_d = amp_q;
        end
        active_d = (state_d != ST_IDLE);
        clear    = note_on || release_ok || (state_d != state_q);
    end

    assign amplitude = amp_q;
    assign active    = active_q;
    assign stage     = state_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Scoreboard bench: the driver pushes model-predicted outputs per cycle,
// the monitor pops and compares them one cycle edge later.
module tb_envelope_sequencer;

    localparam int AW  = 8;
    localparam int RW  = 16;
    localparam int MAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          note_on = 1'b0;
    logic          note_off = 1'b0;
    logic [RW-1:0] attack_rate = '0;
    logic [RW-1:0] decay_rate = '0;
    logic [AW-1:0] sustain_level = '0;
    logic [RW-1:0] release_rate = '0;
    logic [AW-1:0] amplitude;
    logic          active;
    logic [2:0]    stage;

    envelope_sequencer #(
        .AMPLITUDE_BITS (AW),
        .RATE_BITS      (RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .note_on       (note_on),
        .note_off      (note_off),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .amplitude     (amplitude),
        .active        (active),
        .stage         (stage)
    );

    always #5 clk = ~clk;

    typedef struct {
        int amp;
        int stg;
        int act;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    // Stimulus configuration, applied to the DUT only at the next negedge.
    int cfg_rst = 1;
    int cfg_ar  = 0;
    int cfg_dr  = 0;
    int cfg_sl  = 0;
    int cfg_rr  = 0;

    // Reference model: stage 0..4 = idle/attack/decay/sustain/release.
    int m_amp = 0;
    int m_stg = 0;
    int m_cnt = 0;

    task automatic model_reset();
        m_amp = 0;
        m_stg = 0;
        m_cnt = 0;
    endtask

    task automatic model_cycle(input int t, input int on, input int off);
        int  rate;
        int  stepped;
        int  ns;
        int  na;
        int  ev;
        rate = (m_stg == 1) ? cfg_ar : (m_stg == 2) ? cfg_dr : (m_stg == 4) ? cfg_rr : 0;
        stepped = (t != 0) && (m_cnt == rate);
        ns = m_stg;
        na = m_amp;
        ev = (on != 0) || ((off != 0) && m_stg >= 1 && m_stg <= 3);
        if (on != 0) begin
            ns = 1;
        end else if (ev != 0) begin
            ns = 4;
        end else begin
            case (m_stg)
                0: na = 0;
                1: if (stepped != 0) begin
                    na = (m_amp + 1 > MAX) ? MAX : m_amp + 1;
                    if (na == MAX) ns = 2;
                end
                2: if (m_amp <= cfg_sl) begin
                    na = cfg_sl;
                    ns = 3;
                end else if (stepped != 0) begin
                    na = m_amp - 1;
                end
                3: na = cfg_sl;
                4: if (m_amp == 0) ns = 0;
                   else if (stepped != 0) na = m_amp - 1;
                default: ns = 0;
            endcase
        end
        if (ev != 0 || ns != m_stg) m_cnt = 0;
        else if (t != 0) m_cnt = (stepped != 0) ? 0 : (m_cnt + 1) % 65536;
        m_stg = ns;
        m_amp = na;
    endtask

    task automatic drive_cycle(input int t, input int on, input int off);
        exp_t e;
        @(negedge clk);
        rst           = (cfg_rst != 0);
        tick          = (t != 0);
        note_on       = (on != 0);
        note_off      = (off != 0);
        attack_rate   = RW'(cfg_ar);
        decay_rate    = RW'(cfg_dr);
        sustain_level = AW'(cfg_sl);
        release_rate  = RW'(cfg_rr);
        if (cfg_rst != 0) model_reset();
        else model_cycle(t, on, off);
        e.amp = m_amp;
        e.stg = m_stg;
        e.act = (m_stg != 0) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        fails++;
        $display("FAIL %s: cycle budget expired at %0t", name, $time);
    endtask

    // Monitor: every cycle presents one output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_val("amplitude", int'(amplitude), e.amp);
                check_val("stage", int'(stage), e.stg);
                check_val("active", int'(active), e.act);
            end
        end
    end

    initial begin
        int n;
        // Reset held: outputs at reset values, note events ignored.
        cfg_rst = 1;
        drive_cycle(1, 0, 0);
        drive_cycle(1, 1, 0);
        cfg_rst = 0;
        drive_cycle(1, 0, 0);

        // Full attack at rate 0, decay to sustain 100.
        cfg_ar = 0; cfg_dr = 0; cfg_sl = 100; cfg_rr = 1;
        drive_cycle(1, 1, 0);
        for (int i = 0; i < 255; i++) drive_cycle(1, 0, 0);
        check_val("peak_model_amp", m_amp, MAX);
        for (int i = 0; i < 160; i++) drive_cycle(1, 0, 0);
        cfg_sl = 50;
        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0);
        cfg_sl = 100;
        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0);

        // Release at rate 1 from 100 down to idle.
        drive_cycle(1, 0, 1);
        for (int i = 0; i < 205; i++) drive_cycle(1, 0, 0);

        // Attack at rate 3 for 40 ticks.
        cfg_ar = 3;
        drive_cycle(1, 1, 0);
        for (int i = 0; i < 40; i++) drive_cycle(1, 0, 0);

        // Retrigger from release at amplitude 40 with simultaneous note_off.
        cfg_ar = 0; cfg_rr = 0;
        n = 0;
        while (m_amp < 80 && n < 300) begin drive_cycle(1, 0, 0); n++; end
        if (n >= 300) bound_fail("reach_80");
        drive_cycle(1, 0, 1);
        n = 0;
        while (!(m_stg == 4 && m_amp == 40) && n < 300) begin drive_cycle(1, 0, 0); n++; end
        if (n >= 300) bound_fail("reach_release_40");
        drive_cycle(1, 1, 1);
        for (int i = 0; i < 5; i++) drive_cycle(1, 0, 0);

        // Asynchronous reset mid-attack at amplitude 77.
        n = 0;
        while (!(m_stg == 1 && m_amp == 77) && n < 300) begin drive_cycle(1, 0, 0); n++; end
        if (n >= 300) bound_fail("reach_attack_77");
        @(posedge clk);
        #3;
        rst = 1'b1;
        cfg_rst = 1;
        model_reset();
        #1;
        check_val("async_rst_amplitude", int'(amplitude), 0);
        check_val("async_rst_stage", int'(stage), 0);
        check_val("async_rst_active", int'(active), 0);
        drive_cycle(1, 1, 0);
        drive_cycle(1, 0, 1);
        cfg_rst = 0;
        drive_cycle(1, 1, 0);
        for (int i = 0; i < 5; i++) drive_cycle(1, 0, 0);

        // Randomized phase with live rate and sustain changes.
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                cfg_ar = $urandom_range(0, 3);
                cfg_dr = $urandom_range(0, 3);
                cfg_rr = $urandom_range(0, 3);
                case ($urandom_range(0, 3))
                    0: cfg_sl = 0;
                    1: cfg_sl = MAX;
                    default: cfg_sl = $urandom_range(0, MAX);
                endcase
            end
            drive_cycle(($urandom_range(0, 3) != 0) ? 1 : 0,
                        ($urandom_range(0, 199) < 3) ? 1 : 0,
                        ($urandom_range(0, 99) < 3) ? 1 : 0);
        end

        @(negedge clk);
        note_on = 1'b0;
        note_off = 1'b0;
        @(posedge clk);
        #3;
        check_val("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
